// File: rtl/fixed_dot_product_if.sv
// rtl/fixed_dot_product_if.sv - joined data/weight streams and result stream of fixed_dot_product
interface fixed_dot_product_if #(
  parameter int IN_WIDTH     = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IN_SIZE      = 4,
  localparam int OUT_WIDTH   = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE)
);
  logic signed [IN_WIDTH-1:0]     data_in [IN_SIZE];
  logic                           data_in_valid;
  logic                           data_in_ready;
  logic signed [WEIGHT_WIDTH-1:0] weight [IN_SIZE];
  logic                           weight_valid;
  logic                           weight_ready;
  logic signed [OUT_WIDTH-1:0]    data_out;
  logic                           data_out_valid;
  logic                           data_out_ready;

  modport master (
    output data_in, data_in_valid, weight, weight_valid, data_out_ready,
    input  data_in_ready, weight_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, weight, weight_valid, data_out_ready,
    output data_in_ready, weight_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fixed_dot_product.sv
// rtl/fixed_dot_product.sv - signed fixed-point dot product, joined streams, adder tree, 1-cycle output reg
// FIXED_DOT_PRODUCT_PIPE_EN adds a product register stage (latency 2).
module fixed_dot_product #(
  parameter int IN_WIDTH     = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IN_SIZE      = 4
) (
  input  logic               clk,
  input  logic               rst,
  fixed_dot_product_if.slave bus
);
  localparam int PW        = IN_WIDTH + WEIGHT_WIDTH;
  localparam int LEVELS    = $clog2(IN_SIZE);
  localparam int OUT_WIDTH = PW + LEVELS;

  logic                        adv;
  logic                        fire;
  logic signed [PW-1:0]        prod [IN_SIZE];
  logic signed [PW-1:0]        prod_s [IN_SIZE];
  logic                        src_valid;
  logic signed [OUT_WIDTH-1:0] sum;
  logic signed [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                        valid_q, valid_d;

  assign adv               = !valid_q || bus.data_out_ready;
  assign fire              = adv && bus.data_in_valid && bus.weight_valid;
  assign bus.data_in_ready = fire;
  assign bus.weight_ready  = fire;

  always_comb begin
    for (int i = 0; i < IN_SIZE; i++) begin
      prod[i] = PW'(bus.data_in[i]) * PW'(bus.weight[i]);
    end
  end

`ifdef FIXED_DOT_PRODUCT_PIPE_EN
  logic                 stage_valid_q, stage_valid_d;
  logic signed [PW-1:0] prod_q [IN_SIZE];
  logic signed [PW-1:0] prod_d [IN_SIZE];

  always_comb begin
    stage_valid_d = adv ? fire : stage_valid_q;
    for (int i = 0; i < IN_SIZE; i++) begin
      prod_d[i] = fire ? prod[i] : prod_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      for (int i = 0; i < IN_SIZE; i++) prod_q[i] <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      for (int i = 0; i < IN_SIZE; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign src_valid = stage_valid_q;
  always_comb begin
    for (int i = 0; i < IN_SIZE; i++) prod_s[i] = prod_q[i];
  end
`else
  assign src_valid = fire;
  always_comb begin
    for (int i = 0; i < IN_SIZE; i++) prod_s[i] = prod[i];
  end
`endif

  // Level l holds ceil(IN_SIZE/2^l) nodes of width PW+l; an odd last node is sign-extended through.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N  = (IN_SIZE + (1 << l) - 1) >> l;
    localparam int W  = PW + l;
    logic signed [W-1:0] node [N];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_n
        assign node[i] = prod_s[i];
      end
    end else begin : g_add
      localparam int NP = (IN_SIZE + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar i = 0; i < N; i++) begin : g_n
        if (2 * i + 1 < NP) begin : g_sum
          assign node[i] = W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
        end else begin : g_pass
          assign node[i] = W'(g_lvl[l-1].node[2*i]);
        end
      end
    end
  end

  assign sum = g_lvl[LEVELS].node[0];

  always_comb begin
    valid_d    = valid_q;
    data_out_d = data_out_q;
    if (adv) begin
      valid_d = src_valid;
      if (src_valid) data_out_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = valid_q;
endmodule

// File: tb/tb_fixed_dot_product.sv
// tb/tb_fixed_dot_product.sv - directed self-checking bench for fixed_dot_product
module tb_fixed_dot_product;
  localparam int LAT =
`ifdef FIXED_DOT_PRODUCT_PIPE_EN
    2;
`else
    1;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fixed_dot_product_if #(.IN_WIDTH(16), .WEIGHT_WIDTH(8), .IN_SIZE(4)) bus ();

  fixed_dot_product #(.IN_WIDTH(16), .WEIGHT_WIDTH(8), .IN_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int d0, d1, d2, d3, w0, w1, w2, w3);
    bus.data_in[0] = 16'(d0); bus.data_in[1] = 16'(d1);
    bus.data_in[2] = 16'(d2); bus.data_in[3] = 16'(d3);
    bus.weight[0]  = 8'(w0);  bus.weight[1]  = 8'(w1);
    bus.weight[2]  = 8'(w2);  bus.weight[3]  = 8'(w3);
  endtask

  // Offer the current vector with both valids, expect acceptance and the result LAT edges later.
  task automatic send_check(input string tag, input int exp);
    bus.data_in_valid = 1'b1;
    bus.weight_valid  = 1'b1;
    @(negedge clk);
    chk({tag, "_din_rdy"}, bus.data_in_ready, 1);
    chk({tag, "_wt_rdy"}, bus.weight_ready, 1);
    tick();
    bus.data_in_valid = 1'b0;
    bus.weight_valid  = 1'b0;
    repeat (LAT - 1) tick();
    chk({tag, "_valid"}, bus.data_out_valid, 1);
    chk({tag, "_data"}, bus.data_out, exp);
  endtask

  function automatic int exp5(input int k);
    return (100 * k - 300) * (k - 4) + 3 * k - 7 * k - 10;
  endfunction

  initial begin
    rst = 1'b0;
    bus.data_in_valid  = 1'b0;
    bus.weight_valid   = 1'b0;
    bus.data_out_ready = 1'b1;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_valid", bus.data_out_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_din_rdy", bus.data_in_ready, 0);
    rst = 1'b1;
    tick();

    // 1: basic
    set_vec(1, 2, 3, 4, 1, 1, 1, 1);
    send_check("t1", 10);
    tick();
    chk("t1_valid_drop", bus.data_out_valid, 0);

    // 2: most negative operands, mixed signs
    set_vec(-32768, -32768, -32768, -32768, -128, -128, -128, -128);
    send_check("t2a", 16777216);
    set_vec(-1, 2, -3, 4, 5, 5, 5, 5);
    send_check("t2b", 10);
    tick();

    // 3: stall holds output and blocks inputs
    bus.data_out_ready = 1'b0;
    set_vec(1, 1, 1, 1, 2, 2, 2, 2);
    send_check("t3a", 8);
    set_vec(3, 0, 0, 0, 3, 0, 0, 0);
    bus.data_in_valid = 1'b1;
    bus.weight_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_stall_din_rdy", bus.data_in_ready, 0);
      chk("t3_stall_wt_rdy", bus.weight_ready, 0);
      chk("t3_stall_valid", bus.data_out_valid, 1);
      chk("t3_stall_data", bus.data_out, 8);
    end
    bus.data_out_ready = 1'b1;
    send_check("t3b", 9);
    tick();
    chk("t3_valid_drop", bus.data_out_valid, 0);

    // 4: weight missing, no consumption
    set_vec(7, -2, 0, 1, 3, 4, -1, -6);
    bus.data_in_valid = 1'b1;
    bus.weight_valid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_din_rdy", bus.data_in_ready, 0);
      chk("t4_wt_rdy", bus.weight_ready, 0);
      chk("t4_valid", bus.data_out_valid, 0);
    end
    send_check("t4", 7);
    tick();
    chk("t4_single", bus.data_out_valid, 0);

    // 5: back-to-back stream
    for (int c = 0; c < 8 + LAT; c++) begin
      if (c < 8) begin
        set_vec(100 * c - 300, c, -c, 5, c - 4, 3, 7, -2);
        bus.data_in_valid = 1'b1;
        bus.weight_valid  = 1'b1;
      end else begin
        bus.data_in_valid = 1'b0;
        bus.weight_valid  = 1'b0;
      end
      tick();
      if (c >= LAT - 1 && c - LAT + 1 < 8) begin
        chk("t5_valid", bus.data_out_valid, 1);
        chk("t5_data", bus.data_out, exp5(c - LAT + 1));
      end
    end
    chk("t5_end_valid", bus.data_out_valid, 0);

    // 6: reset while stalled drops the result
    bus.data_out_ready = 1'b0;
    set_vec(2, 2, 2, 2, 3, 3, 3, 3);
    send_check("t6", 24);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rst_valid", bus.data_out_valid, 0);
    chk("t6_rst_data", bus.data_out, 0);
    rst = 1'b1;
    bus.data_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_stale", bus.data_out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
